piece_counter: RTL and testbench
================================

PIECE_COUNTER -- requirements
Module: piece_counter

Interface
REQ-001 Parameter N_PLAYERS, default 2; number of player boards scanned in parallel.
REQ-002 Parameter DEPTH, default 11; ship entries per board, at memory addresses 0..DEPTH-1.
REQ-003 Parameter WORD_W, default 64; width of one board memory word.
REQ-004 Parameter FIELD_MSB, default 42; MSB of the hit-status field within a word.
REQ-005 Parameter FIELD_W, default 40; width of the hit-status field, bits FIELD_MSB down to FIELD_MSB-FIELD_W+1.
REQ-006 Derived ADDR_W = clog2(DEPTH) (minimum 1); derived CNT_W = clog2(DEPTH+1).
REQ-007 clk  in  1  single system clock, all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 start  in  1  scan request, sampled only in IDLE.
REQ-010 mem_rdata  in  N_PLAYERS*WORD_W  read data, player p in slice [p*WORD_W +: WORD_W], valid one cycle after mem_en.
REQ-011 mem_addr  out  ADDR_W  shared read address for all player memories.
REQ-012 mem_en  out  1  read strobe.
REQ-013 busy  out  1  high while a scan is in progress.
REQ-014 done  out  1  one-cycle pulse; results valid.
REQ-015 qtd  out  N_PLAYERS*CNT_W  ships remaining per player, player p in [p*CNT_W +: CNT_W].
REQ-016 all_sunk  out  N_PLAYERS  bit p high when player p's qtd equals 0.

Function
REQ-017 FSM states IDLE, SCAN, DRAIN, DONE; only legal transitions are IDLE->SCAN on start, SCAN->DRAIN after the address DEPTH-1 cycle, DRAIN->DONE, DONE->IDLE.
REQ-018 Start accepted in cycle 0; cycles 1..DEPTH are SCAN with mem_en=1 and mem_addr=k-1 in cycle k.
REQ-019 Cycle DEPTH+1 is DRAIN (mem_en=0), capturing the last word; cycle DEPTH+2 is DONE with done=1; start-to-done latency exactly DEPTH+2 cycles.
REQ-020 busy=1 in SCAN and DRAIN only; mem_addr=0 and mem_en=0 outside SCAN.
REQ-021 A returned word counts as a surviving ship when its hit-status field is non-zero; a zero field counts as sunk; bits outside the field are ignored.
REQ-022 Per-player accumulators clear on start acceptance and increment by at most 1 per data cycle; the width is CNT_W, so an accumulator cannot overflow.
REQ-023 qtd and all_sunk update only on the edge entering DONE and hold their value otherwise, including throughout a scan.
REQ-024 start while busy or in DONE is ignored without side effects; start held high continuously begins a new scan at each return to IDLE.
REQ-025 mem_rdata is ignored outside the DEPTH data-capture cycles.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, busy=0, done=0, mem_en=0, mem_addr=0, every qtd lane=DEPTH, all_sunk=0, accumulators=0.
REQ-027 Reset asserted mid-scan aborts the scan, produces no done pulse, and restores the REQ-026 values.
REQ-028 The first start after rst_n deasserts behaves identically to any other scan.

Structure
REQ-029 Package piece_counter_pkg holds the FSM state enum and the default values of all parameters.
REQ-030 Sub-module piece_lane is instantiated N_PLAYERS times; each lane holds the field test, accumulator, qtd register and all_sunk flag for one player.

Verification
REQ-031 Reset with defaults -> qtd lanes=11 each, all_sunk=00, busy=0, done=0.
REQ-032 Start with defaults; P1 all fields non-zero, P2 fields zero at addr 2,5,9 -> done at cycle 13, qtd P1=11, P2=8, all_sunk=00.
REQ-033 All P2 fields zero, P2 words with bit 63 and bit 0 set -> qtd P2=0, all_sunk[1]=1.
REQ-034 Start pulsed at cycles 4 and 13 of a scan -> exactly one done, at cycle 13; no second scan starts.
REQ-035 rst_n low in cycle 6 of a scan -> no done pulse, REQ-026 values, next scan correct.
REQ-036 DEPTH=5, N_PLAYERS=3 -> mem_addr 0..4, done at cycle 7, CNT_W=3, counts match the model.

Source files
------------

// File: rtl/piece_counter_pkg.sv
// Shared types, default parameters and helpers for the piece counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package piece_counter_pkg;

  localparam int DEF_N_PLAYERS = 2;
  localparam int DEF_DEPTH     = 11;
  localparam int DEF_WORD_W    = 64;
  localparam int DEF_FIELD_MSB = 42;
  localparam int DEF_FIELD_W   = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Address width never collapses to zero, even for a single-entry board.
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piece_counter_if.sv
// Control, board-memory read bus and result signals of one piece counter.
// Latency: n/a (wiring only).
// Backpressure: none; memory returns data a fixed one cycle after the strobe.
interface piece_counter_if
  import piece_counter_pkg::*;
#(
  parameter int N_PLAYERS = DEF_N_PLAYERS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WORD_W    = DEF_WORD_W
);

  localparam int ADDR_W = clog2_min1(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                        start;
  logic [N_PLAYERS*WORD_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]           mem_addr;
  logic                        mem_en;
  logic                        busy;
  logic                        done;
  logic [N_PLAYERS*CNT_W-1:0]  qtd;
  logic [N_PLAYERS-1:0]        all_sunk;

  // Requester / memory side: issues start, supplies read data, observes results.
  modport master (
    output start, mem_rdata,
    input  mem_addr, mem_en, busy, done, qtd, all_sunk
  );

  // Counter side.
  modport slave (
    input  start, mem_rdata,
    output mem_addr, mem_en, busy, done, qtd, all_sunk
  );

endinterface

// File: rtl/piece_lane.sv
// One player's lane: hit-field test, surviving-ship accumulator, result registers.
// Latency: result registers load on the cycle the final word is captured.
// Backpressure: none; a word is counted on every cycle i_cap_vld is high.
module piece_lane
  import piece_counter_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int CNT_W   = $clog2(DEF_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_cap_vld,
  input  logic [FIELD_W-1:0] i_field,
  input  logic               i_load,
  output logic [CNT_W-1:0]   o_qtd,
  output logic               o_all_sunk
);

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_qtd;
  logic             r_all_sunk;
  logic             w_hit;
  logic [CNT_W-1:0] w_acc_nxt;

  // A ship survives while any bit of its hit-status field is still set.
  assign w_hit     = i_cap_vld && (|i_field);
  assign w_acc_nxt = r_acc + CNT_W'(w_hit);

  // Accumulator: cleared when a scan is accepted, bumped by one per surviving ship.
  // CNT_W holds DEPTH, and at most DEPTH words are captured, so no wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

  // Results load on the edge into DONE, folding in the last word captured in DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qtd      <= CNT_W'(DEPTH);
      r_all_sunk <= 1'b0;
    end else if (i_load) begin
      r_qtd      <= w_acc_nxt;
      r_all_sunk <= (w_acc_nxt == '0);
    end
  end

  assign o_qtd      = r_qtd;
  assign o_all_sunk = r_all_sunk;

endmodule

// File: rtl/piece_counter.sv
// Scans every player's ship table in parallel and reports ships still afloat.
// Latency: done pulses exactly DEPTH+2 cycles after the start is accepted.
// Backpressure: start is only sampled in IDLE; requests while busy/done are dropped.
module piece_counter
  import piece_counter_pkg::*;
#(
  parameter int N_PLAYERS = DEF_N_PLAYERS,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int FIELD_MSB = DEF_FIELD_MSB,
  parameter int FIELD_W   = DEF_FIELD_W
) (
  input  logic           clk,
  input  logic           rst_n,
  piece_counter_if.slave bus
);

  localparam int ADDR_W = clog2_min1(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_vld;
  logic              w_accept;
  logic              w_last_addr;
  logic              w_busy;
  logic              w_done;
  logic              w_mem_en;
  logic              w_unused_rdata;

  assign w_accept    = (r_state == ST_IDLE) && bus.start;
  assign w_last_addr = (r_addr == ADDR_W'(DEPTH - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state outputs; DONE always returns to IDLE for one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_mem_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        w_busy   = 1'b1;
        w_mem_en = 1'b1;
        if (w_last_addr) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read address walks 0..DEPTH-1 during SCAN and rests at zero everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if ((r_state == ST_SCAN) && !w_last_addr) begin
      r_addr <= r_addr + ADDR_W'(1);
    end else begin
      r_addr <= '0;
    end
  end

  // Read data is valid exactly one cycle after the strobe; this marks those cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld <= 1'b0;
    end else begin
      r_rd_vld <= w_mem_en;
    end
  end

  assign bus.mem_en   = w_mem_en;
  assign bus.mem_addr = w_mem_en ? r_addr : '0;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;

  // Bits outside the hit-status field carry nothing this block needs.
  assign w_unused_rdata = ^bus.mem_rdata;

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_lane
    piece_lane #(
      .DEPTH   (DEPTH),
      .FIELD_W (FIELD_W),
      .CNT_W   (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_accept),
      .i_cap_vld  (r_rd_vld),
      .i_field    (bus.mem_rdata[p*WORD_W + FIELD_MSB -: FIELD_W]),
      .i_load     (r_state == ST_DRAIN),
      .o_qtd      (bus.qtd[p*CNT_W +: CNT_W]),
      .o_all_sunk (bus.all_sunk[p])
    );
  end

endmodule

// File: tb/tb_piece_counter.sv
// Scoreboard bench for piece_counter: default build plus a DEPTH=5, 3-player build.
// Expected results are hand-computed and queued at start; negedge monitors compare.
// Memory models return all-ones outside read cycles so stray captures show up.
module tb_piece_counter;
  import piece_counter_pkg::*;

  localparam int N0 = 2;
  localparam int D0 = 11;
  localparam int N1 = 3;
  localparam int D1 = 5;

  typedef struct {
    logic [63:0] qtd;
    logic [63:0] sunk;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  int   ea0 = 0;
  int   ea1 = 0;
  int   c;

  logic [63:0] m0 [N0][16];
  logic [63:0] m1 [N1][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piece_counter_if #(.N_PLAYERS(N0), .DEPTH(D0), .WORD_W(64)) if0 ();
  piece_counter_if #(.N_PLAYERS(N1), .DEPTH(D1), .WORD_W(64)) if1 ();

  piece_counter #(.N_PLAYERS(N0), .DEPTH(D0), .WORD_W(64), .FIELD_MSB(42), .FIELD_W(40))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  piece_counter #(.N_PLAYERS(N1), .DEPTH(D1), .WORD_W(64), .FIELD_MSB(42), .FIELD_W(40))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Board memories: one-cycle read latency, garbage when not strobed.
  always @(posedge clk) begin
    for (int p = 0; p < N0; p++)
      if0.mem_rdata[p*64 +: 64] <= if0.mem_en ? m0[p][if0.mem_addr] : '1;
    for (int p = 0; p < N1; p++)
      if1.mem_rdata[p*64 +: 64] <= if1.mem_en ? m1[p][if1.mem_addr] : '1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Field bits are [42:3]; live words set some field bit, dead words only outside bits.
  function automatic logic [63:0] live_w(input int i);
    case (i % 3)
      0:       return 64'h0000_0000_0000_0008;
      1:       return 64'h0000_0400_0000_0000;
      default: return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  function automatic logic [63:0] dead_w(input int i);
    return (i % 2 == 1) ? 64'h8000_0000_0000_0001 : 64'hFFFF_F800_0000_0007;
  endfunction

  // Monitor for the default build: address sequence every cycle, results on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      ea0 = 0;
    end else begin
      if (if0.mem_en) begin
        chk("addr0", 64'(if0.mem_addr), 64'(ea0));
        ea0++;
      end else begin
        chk("addr0_idle", 64'(if0.mem_addr), 64'd0);
      end
      if (if0.done) begin
        if (q0.size() == 0) begin
          chk("done0_unexpected", 64'(if0.done), 64'd0);
        end else begin
          e0 = q0.pop_front();
          chk("qtd0", 64'(if0.qtd), e0.qtd);
          chk("sunk0", 64'(if0.all_sunk), e0.sunk);
          chk("done0_cycle", 64'(cyc), 64'(e0.cyc));
          chk("reads0", 64'(ea0), 64'(D0));
          chk("busy0_in_done", 64'(if0.busy), 64'd0);
        end
        ea0 = 0;
      end
    end
  end

  // Monitor for the small build.
  always @(negedge clk) begin
    if (!rst_n) begin
      ea1 = 0;
    end else begin
      if (if1.mem_en) begin
        chk("addr1", 64'(if1.mem_addr), 64'(ea1));
        ea1++;
      end
      if (if1.done) begin
        if (q1.size() == 0) begin
          chk("done1_unexpected", 64'(if1.done), 64'd0);
        end else begin
          e1 = q1.pop_front();
          chk("qtd1", 64'(if1.qtd), e1.qtd);
          chk("sunk1", 64'(if1.all_sunk), e1.sunk);
          chk("done1_cycle", 64'(cyc), 64'(e1.cyc));
          chk("reads1", 64'(ea1), 64'(D1));
        end
        ea1 = 0;
      end
    end
  end

  // Pulse start for one cycle; returns the cycle in which it was accepted.
  task automatic pulse0(output int c0);
    @(negedge clk);
    if0.start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  task automatic drain0();
    int k = 0;
    while (q0.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (q0.size() != 0) begin
      chk("timeout0_pending", 64'(q0.size()), 64'd0);
      q0.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic load_a();
    for (int i = 0; i < D0; i++) begin
      m0[0][i] = live_w(i);
      m0[1][i] = (i == 2 || i == 5 || i == 9) ? dead_w(i) : live_w(i + 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang, want finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    if0.start = 1'b0;
    if1.start = 1'b0;
    for (int p = 0; p < N0; p++) for (int i = 0; i < 16; i++) m0[p][i] = '0;
    for (int p = 0; p < N1; p++) for (int i = 0; i < 8; i++) m1[p][i] = '0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_qtd0", 64'(if0.qtd), 64'h0BB);
    chk("rst_sunk0", 64'(if0.all_sunk), 64'd0);
    chk("rst_busy0", 64'(if0.busy), 64'd0);
    chk("rst_done0", 64'(if0.done), 64'd0);
    chk("rst_en0", 64'(if0.mem_en), 64'd0);
    chk("rst_qtd1", 64'(if1.qtd), 64'h16D);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // P0 all live, P1 dead at 2,5,9 -> {8,11}.
    load_a();
    pulse0(c);
    q0.push_back('{qtd: 64'h08B, sunk: 64'd0, cyc: c + D0 + 2});
    chk("busy0_scan", 64'(if0.busy), 64'd1);
    chk("qtd0_hold_reset", 64'(if0.qtd), 64'h0BB);
    drain0();

    // P0 live only at the last address, P1 all dead with bits 63/0 set -> {0,1}.
    for (int i = 0; i < D0; i++) begin
      m0[0][i] = (i == D0 - 1) ? live_w(i) : dead_w(i);
      m0[1][i] = 64'h8000_0000_0000_0001;
    end
    pulse0(c);
    q0.push_back('{qtd: 64'h001, sunk: 64'h2, cyc: c + D0 + 2});
    repeat (5) @(negedge clk);
    chk("qtd0_hold_scan", 64'(if0.qtd), 64'h08B);
    chk("sunk0_hold_scan", 64'(if0.all_sunk), 64'd0);
    drain0();

    // Extra start pulses at cycles 4 and 13 of a scan are ignored -> {11,1}.
    for (int i = 0; i < D0; i++) begin
      m0[0][i] = (i == 0) ? live_w(1) : dead_w(i);
      m0[1][i] = live_w(i);
    end
    pulse0(c);
    q0.push_back('{qtd: 64'h0B1, sunk: 64'd0, cyc: c + D0 + 2});
    repeat (3) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("done0_at_13", 64'(if0.done), 64'd1);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    chk("busy0_no_rescan", 64'(if0.busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("busy0_still_idle", 64'(if0.busy), 64'd0);
    drain0();

    // Reset in cycle 6 aborts the scan with no done pulse.
    pulse0(c);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_qtd0", 64'(if0.qtd), 64'h0BB);
    chk("abort_sunk0", 64'(if0.all_sunk), 64'd0);
    chk("abort_busy0", 64'(if0.busy), 64'd0);
    chk("abort_en0", 64'(if0.mem_en), 64'd0);
    chk("abort_addr0", 64'(if0.mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    load_a();
    pulse0(c);
    q0.push_back('{qtd: 64'h08B, sunk: 64'd0, cyc: c + D0 + 2});
    drain0();

    // Start held high: back-to-back scans, all dead -> {0,0}, all_sunk=11.
    for (int i = 0; i < D0; i++) begin
      m0[0][i] = dead_w(i);
      m0[1][i] = dead_w(i + 1);
    end
    @(negedge clk);
    if0.start = 1'b1;
    c = cyc;
    q0.push_back('{qtd: 64'h000, sunk: 64'h3, cyc: c + D0 + 2});
    q0.push_back('{qtd: 64'h000, sunk: 64'h3, cyc: c + 2 * D0 + 5});
    repeat (15) @(negedge clk);
    if0.start = 1'b0;
    drain0();

    // Small build: P0 live at 0,2,4 -> 3; P1 dead -> 0; P2 live -> 5.
    for (int i = 0; i < D1; i++) begin
      m1[0][i] = (i % 2 == 0) ? live_w(i) : dead_w(i);
      m1[1][i] = dead_w(i);
      m1[2][i] = live_w(i);
    end
    @(negedge clk);
    if1.start = 1'b1;
    c = cyc;
    q1.push_back('{qtd: 64'h143, sunk: 64'h2, cyc: c + D1 + 2});
    @(negedge clk);
    if1.start = 1'b0;
    for (int k = 0; k < 100 && q1.size() != 0; k++) @(negedge clk);
    if (q1.size() != 0) begin
      chk("timeout1_pending", 64'(q1.size()), 64'd0);
      q1.delete();
    end
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
